// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//
// Direct-mapped branch target buffer with per-entry saturating counters.
// The fetch stage looks up pc_fetch combinationally and gets a next-PC plus
// a snapshot (index, counter). The EX stage writes resolved conditional
// branches back through one update port, addressed by the index captured at
// fetch time.
//
// Optional feature: define BP_GSHARE_EN to add an IDX_W-bit global history
// register that is XORed into the fetch index (gshare). History shifts in
// the resolved outcome on every update.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-low reset
//   pc_fetch       PC being fetched
//   predict_hit    valid entry with matching tag at predict_idx
//   predict_taken  hit and counter MSB set
//   predict_target stored target when taken, else pc_fetch + 4
//   predict_idx    table index used (carried down the pipe)
//   predict_ctr    counter value read at predict_idx
//   update_en      one resolved conditional branch this cycle
//   update_pc      PC of the resolved branch
//   update_idx     predict_idx captured at fetch of that branch
//   update_taken   actual outcome
//   update_target  actual taken target
module branch_target_predictor #(
  parameter  int ENTRIES = 16,
  parameter  int CTR_W   = 2,
  parameter  int XLEN    = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_fetch,
  output logic             predict_hit,
  output logic             predict_taken,
  output logic [XLEN-1:0]  predict_target,
  output logic [IDX_W-1:0] predict_idx,
  output logic [CTR_W-1:0] predict_ctr,
  input  logic             update_en,
  input  logic [XLEN-1:0]  update_pc,
  input  logic [IDX_W-1:0] update_idx,
  input  logic             update_taken,
  input  logic [XLEN-1:0]  update_target
);

  localparam int TAG_W = XLEN - 2 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  // Next-state of the single entry addressed by update_idx.
  logic               valid_d;
  logic [TAG_W-1:0]   tag_d;
  logic [XLEN-1:0]    target_d;
  logic [CTR_W-1:0]   ctr_d;

  logic [IDX_W-1:0]   fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic [TAG_W-1:0]   upd_tag;
  logic [CTR_W-1:0]   upd_ctr;
  logic               upd_hit;

  // Low PC bits of the resolved branch are implied by update_idx.
  logic unused_upd_pc;
  assign unused_upd_pc = ^update_pc[2+IDX_W-1:0];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;
  logic [IDX_W:0]   ghr_shift;

  // Shifting through a one-bit-wider vector covers IDX_W = 1 as well.
  always_comb begin
    ghr_shift = {ghr_q, update_taken};
    ghr_d     = ghr_shift[IDX_W-1:0];
  end

  assign fetch_idx = pc_fetch[2 +: IDX_W] ^ ghr_q;
`else
  assign fetch_idx = pc_fetch[2 +: IDX_W];
`endif

  // Predict path: purely combinational from pc_fetch and current state.
  always_comb begin
    fetch_tag      = pc_fetch[XLEN-1 -: TAG_W];
    predict_idx    = fetch_idx;
    predict_ctr    = ctr_q[fetch_idx];
    predict_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predict_taken  = predict_hit && predict_ctr[CTR_W-1];
    predict_target = predict_taken ? target_q[fetch_idx] : pc_fetch + XLEN'(4);
  end

  // Update path: compute the new contents of entry update_idx.
  always_comb begin
    upd_tag  = update_pc[XLEN-1 -: TAG_W];
    upd_ctr  = ctr_q[update_idx];
    upd_hit  = valid_q[update_idx] && (tag_q[update_idx] == upd_tag);
    valid_d  = valid_q[update_idx];
    tag_d    = tag_q[update_idx];
    target_d = target_q[update_idx];
    ctr_d    = upd_ctr;
    if (update_taken) begin
      target_d = update_target;
      if (upd_hit) begin
        ctr_d = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + CTR_W'(1);
      end else begin
        // Allocate over whatever was there, starting weakly taken.
        valid_d = 1'b1;
        tag_d   = upd_tag;
        ctr_d   = CTR_WT;
      end
    end else if (upd_hit) begin
      ctr_d = (upd_ctr == '0) ? upd_ctr : upd_ctr - CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
`ifdef BP_GSHARE_EN
      ghr_q <= '0;
`endif
    end else if (update_en) begin
      valid_q[update_idx]  <= valid_d;
      tag_q[update_idx]    <= tag_d;
      target_q[update_idx] <= target_d;
      ctr_q[update_idx]    <= ctr_d;
`ifdef BP_GSHARE_EN
      ghr_q <= ghr_d;
`endif
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_fetch;
  logic        predict_hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [3:0]  predict_idx;
  logic [1:0]  predict_ctr;
  logic        update_en;
  logic [31:0] update_pc;
  logic [3:0]  update_idx;
  logic        update_taken;
  logic [31:0] update_target;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_target_predictor #(.ENTRIES(16), .CTR_W(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc_fetch(pc_fetch),
    .predict_hit(predict_hit), .predict_taken(predict_taken),
    .predict_target(predict_target), .predict_idx(predict_idx),
    .predict_ctr(predict_ctr), .update_en(update_en), .update_pc(update_pc),
    .update_idx(update_idx), .update_taken(update_taken),
    .update_target(update_target)
  );

  // ---------------- behavioural model ----------------
  // Table of 16 entries indexed by word address modulo 16; tag is the PC
  // divided by 64. Counters are plain integers clamped to 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_ghr;
  bit          model_known = 0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_ghr = 0;
      model_known = 1;
    end else if (update_en && model_known) begin
      int e;
      bit h;
      e = int'(update_idx);
      h = m_valid[e] && (m_tag[e] == (update_pc / 64));
      if (update_taken) begin
        m_tgt[e] = update_target;
        if (h) m_ctr[e] = (m_ctr[e] + 1 > 3) ? 3 : m_ctr[e] + 1;
        else begin
          m_valid[e] = 1; m_tag[e] = update_pc / 64; m_ctr[e] = 2;
        end
      end else if (h) begin
        m_ctr[e] = (m_ctr[e] - 1 < 0) ? 0 : m_ctr[e] - 1;
      end
`ifdef BP_GSHARE_EN
      m_ghr = ((m_ghr * 2) + (update_taken ? 1 : 0)) % 16;
`endif
    end
  end

  function automatic int model_idx(input logic [31:0] pc);
    return int'(((pc / 4) % 16) ^ m_ghr);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model();
    int idx;
    bit hit, tk;
    logic [31:0] tgt;
    idx = model_idx(pc_fetch);
    hit = m_valid[idx] && (m_tag[idx] == (pc_fetch / 64));
    tk  = hit && (m_ctr[idx] >= 2);
    tgt = tk ? m_tgt[idx] : pc_fetch + 32'd4;
    chk("model_idx",    32'(predict_idx),   32'(idx));
    chk("model_hit",    32'(predict_hit),   32'(hit));
    chk("model_taken",  32'(predict_taken), 32'(tk));
    chk("model_target", predict_target,     tgt);
    chk("model_ctr",    32'(predict_ctr),   32'(m_ctr[idx]));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle at the falling edge, then compares against the model
  // once outputs have settled. The model advances at the following rising edge.
  task automatic step(input logic r, input logic [31:0] pc, input logic ue,
                      input logic [31:0] upc, input logic [3:0] uidx,
                      input logic ut, input logic [31:0] utgt);
    @(negedge clk);
    rst = r; pc_fetch = pc; update_en = ue; update_pc = upc;
    update_idx = uidx; update_taken = ut; update_target = utgt;
    #1;
    if (model_known) check_model();
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] upc,
                     input logic ut, input logic [31:0] utgt);
    step(1'b1, pc, 1'b1, upc, 4'(model_idx(upc)), ut, utgt);
  endtask

  initial begin
    rst = 1'b0; pc_fetch = 32'h100; update_en = 1'b0; update_pc = 32'h0;
    update_idx = 4'h0; update_taken = 1'b0; update_target = 32'h0;

    step(1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    step(1'b0, 32'h100, 1'b1, 32'h100, 4'h0, 1'b1, 32'h200);

    // Post-reset state, including PC + 4 wrap.
    fetch(32'hFFFF_FFFC);
    chk("wrap_target", predict_target, 32'h0000_0000);
    fetch(32'h100);
    chk("rst_hit",    32'(predict_hit),   32'd0);
    chk("rst_taken",  32'(predict_taken), 32'd0);
    chk("rst_target", predict_target,     32'h104);
    chk("rst_ctr",    32'(predict_ctr),   32'd1);

`ifndef BP_GSHARE_EN
    // Allocate, then next-cycle hit.
    upd(32'h100, 32'h100, 1'b1, 32'h200);
    chk("same_cycle_pre_alloc_hit", 32'(predict_hit), 32'd0);
    fetch(32'h100);
    chk("alloc_hit",    32'(predict_hit),   32'd1);
    chk("alloc_taken",  32'(predict_taken), 32'd1);
    chk("alloc_target", predict_target,     32'h200);
    chk("alloc_ctr",    32'(predict_ctr),   32'd2);
    repeat (4) upd(32'h100, 32'h100, 1'b1, 32'h200);
    fetch(32'h100);
    chk("sat_hi_ctr", 32'(predict_ctr), 32'd3);
    repeat (3) upd(32'h100, 32'h100, 1'b0, 32'h0);
    fetch(32'h100);
    chk("dec_ctr",    32'(predict_ctr),   32'd0);
    chk("dec_taken",  32'(predict_taken), 32'd0);
    chk("dec_target", predict_target,     32'h104);
    upd(32'h100, 32'h100, 1'b0, 32'h0);
    fetch(32'h100);
    chk("sat_lo_ctr", 32'(predict_ctr), 32'd0);
    chk("sat_lo_hit", 32'(predict_hit), 32'd1);
    // Aliasing: same index, different tag.
    upd(32'h100, 32'h140, 1'b1, 32'h300);
    fetch(32'h100);
    chk("alias_old_miss", 32'(predict_hit), 32'd0);
    fetch(32'h140);
    chk("alias_new_hit",    32'(predict_hit), 32'd1);
    chk("alias_new_target", predict_target,   32'h300);
    // Same-cycle predict and update of the same entry.
    upd(32'h140, 32'h140, 1'b1, 32'h300);
    chk("same_cycle_old_ctr", 32'(predict_ctr), 32'd2);
    fetch(32'h140);
    chk("same_cycle_new_ctr", 32'(predict_ctr), 32'd3);
`else
    upd(32'h100, 32'h100, 1'b1, 32'h200);
    upd(32'h104, 32'h104, 1'b0, 32'h0);
    fetch(32'h108);
    chk("gshare_idx", 32'(predict_idx), 32'd0);
    upd(32'h100, 32'h140, 1'b1, 32'h300);
`endif

    // Mid-stream reset discards the concurrent update.
    step(1'b0, 32'h140, 1'b1, 32'h140, 4'h0, 1'b1, 32'h300);
    fetch(32'h140);
    chk("midrst_hit", 32'(predict_hit), 32'd0);
    chk("midrst_ctr", 32'(predict_ctr), 32'd1);

    // Randomised phase: small PC pool so entries collide and hit often.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc, upc, tgt;
      logic [3:0]  uidx;
      pc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 19) == 0) pc = $urandom;
      upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      tgt = $urandom;
      uidx = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(model_idx(upc));
      step(($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1, pc,
           1'($urandom_range(0, 1)), upc, uidx, 1'($urandom_range(0, 1)), tgt);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
